// File: rtl/patch_pkg.sv
// rtl/patch_pkg.sv - shared types and frame layout helpers for the patch control unit
//
// Purpose : FSM state encoding and the configuration frame field layout.
//           The frame is LSB-first: match_mask, match_val, ctrl_mask,
//           ctrl_value, hold_cnt. Offsets depend on the instance widths,
//           so they are provided as constant functions of those widths.
// Ports   : none (package).
package patch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_FIRE  = 2'd3
    } state_e;

    // Field offsets within the frame register
    localparam int OFF_MATCH_MASK = 0;

    function automatic int off_match_val(input int obs_w);
        return obs_w;
    endfunction

    function automatic int off_ctrl_mask(input int obs_w);
        return 2 * obs_w;
    endfunction

    function automatic int off_ctrl_value(input int obs_w, input int ctrl_w);
        return 2 * obs_w + ctrl_w;
    endfunction

    function automatic int off_hold(input int obs_w, input int ctrl_w);
        return 2 * obs_w + 2 * ctrl_w;
    endfunction

    function automatic int frame_width(input int obs_w, input int ctrl_w, input int hold_w);
        return 2 * obs_w + 2 * ctrl_w + hold_w;
    endfunction

endpackage

// File: rtl/patch_obs_sync.sv
// rtl/patch_obs_sync.sv - two-flop synchronizer for the observed signal vector
//
// Purpose : brings obs_in into the clk domain before matching; adds two
//           cycles of latency. Only instantiated with PATCH_OBS_SYNC_EN.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset (flops clear to 0)
//           d_i   - asynchronous input vector
//           q_o   - synchronized output vector
module patch_obs_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/patch_control_unit.sv
// rtl/patch_control_unit.sv - serially configured match-and-override patch controller
//
// Purpose : loads a configuration frame bit-serially, then watches obs_in for
//           a masked match and drives override values onto ctrl_en/ctrl_val
//           for hold_cnt cycles (or indefinitely when hold_cnt is 0).
// Option  : PATCH_OBS_SYNC_EN - route obs_in through a 2-flop synchronizer.
// Ports   : clk       - clock, rising edge
//           rst_n     - asynchronous active-low reset
//           cfg_valid - serial config bit qualifier
//           cfg_data  - serial config bit
//           cfg_ready - config bit consumed when cfg_valid is also high
//           obs_in    - observed signals
//           ctrl_en   - per-bit override enables (registered)
//           ctrl_val  - override values (registered)
//           armed     - high while waiting for a match
//           fired     - one-cycle pulse on entry to FIRE
module patch_control_unit
    import patch_pkg::*;
#(
    parameter int OBS_W  = 4,
    parameter int CTRL_W = 4,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic              cfg_data,
    output logic              cfg_ready,
    input  logic [OBS_W-1:0]  obs_in,
    output logic [CTRL_W-1:0] ctrl_en,
    output logic [CTRL_W-1:0] ctrl_val,
    output logic              armed,
    output logic              fired
);

    localparam int FRAME_W   = frame_width(OBS_W, CTRL_W, HOLD_W);
    localparam int CNT_W     = $clog2(FRAME_W);
    localparam int OFF_MVAL  = off_match_val(OBS_W);
    localparam int OFF_CMASK = off_ctrl_mask(OBS_W);
    localparam int OFF_CVAL  = off_ctrl_value(OBS_W, CTRL_W);
    localparam int OFF_HOLD  = off_hold(OBS_W, CTRL_W);

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CTRL_W-1:0]   ctrl_en_q, ctrl_en_d;
    logic [CTRL_W-1:0]   ctrl_val_q, ctrl_val_d;
    logic                fired_q, fired_d;

    logic [OBS_W-1:0]    obs_m;

`ifdef PATCH_OBS_SYNC_EN
    patch_obs_sync #(
        .W (OBS_W)
    ) u_obs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (obs_in),
        .q_o   (obs_m)
    );
`else
    assign obs_m = obs_in;
`endif

    logic [OBS_W-1:0]   match_mask;
    logic [OBS_W-1:0]   match_val;
    logic [CTRL_W-1:0]  ctrl_mask;
    logic [CTRL_W-1:0]  ctrl_value;
    logic [HOLD_W-1:0]  hold_cfg;
    logic               match;
    logic               sticky;
    logic               consume;
    logic [FRAME_W-1:0] frame_shift;

    assign match_mask  = frame_q[OFF_MATCH_MASK +: OBS_W];
    assign match_val   = frame_q[OFF_MVAL +: OBS_W];
    assign ctrl_mask   = frame_q[OFF_CMASK +: CTRL_W];
    assign ctrl_value  = frame_q[OFF_CVAL +: CTRL_W];
    assign hold_cfg    = frame_q[OFF_HOLD +: HOLD_W];

    // An all-zero mask would match everything; treat it as "disabled".
    assign match       = (match_mask != '0) && (((obs_m ^ match_val) & match_mask) == '0);

    // hold_q only sits at 0 inside FIRE when the frame asked for sticky mode;
    // timed FIRE leaves the state while hold_q is still 1.
    assign sticky      = (hold_q == '0);
    assign cfg_ready   = !((state_q == ST_FIRE) && !sticky);
    assign consume     = cfg_valid && cfg_ready;

    // New bits enter at the MSB so the first bit sent ends up at bit 0.
    assign frame_shift = {cfg_data, frame_q[FRAME_W-1:1]};

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        ctrl_en_d  = ctrl_en_q;
        ctrl_val_d = ctrl_val_q;
        fired_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (consume) begin
                    frame_d = frame_shift;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (consume) begin
                    frame_d = frame_shift;
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_ARMED: begin
                // Reconfiguration wins over a coincident match.
                if (consume) begin
                    frame_d = frame_shift;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_LOAD;
                end else if (match) begin
                    ctrl_en_d  = ctrl_mask;
                    ctrl_val_d = ctrl_value & ctrl_mask;
                    hold_d     = hold_cfg;
                    fired_d    = 1'b1;
                    state_d    = ST_FIRE;
                end
            end

            ST_FIRE: begin
                if (sticky) begin
                    if (consume) begin
                        frame_d    = frame_shift;
                        cnt_d      = CNT_W'(1);
                        ctrl_en_d  = '0;
                        ctrl_val_d = '0;
                        state_d    = ST_LOAD;
                    end
                end else if (hold_q == HOLD_W'(1)) begin
                    // Expiry always passes through ARMED, even if obs still matches.
                    hold_d     = '0;
                    ctrl_en_d  = '0;
                    ctrl_val_d = '0;
                    state_d    = ST_ARMED;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            ctrl_en_q  <= '0;
            ctrl_val_q <= '0;
            fired_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_val_q <= ctrl_val_d;
            fired_q    <= fired_d;
        end
    end

    assign ctrl_en  = ctrl_en_q;
    assign ctrl_val = ctrl_val_q;
    assign fired    = fired_q;
    assign armed    = (state_q == ST_ARMED);

endmodule

// File: tb/tb_patch_control_unit.sv
// tb/tb_patch_control_unit.sv - directed self-checking bench for patch_control_unit
module tb_patch_control_unit;

`ifdef PATCH_OBS_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    // mask=0011 val=0001 cmask=0101 cval=0100, hold=3 (timed) / hold=0 (sticky)
    localparam logic [23:0] F_TIMED  = 24'h034513;
    localparam logic [23:0] F_STICKY = 24'h004513;
    // match_mask=0 : must never fire
    localparam logic [23:0] F_NOMASK = 24'h034500;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_data;
    logic       cfg_ready;
    logic [3:0] obs_in;
    logic [3:0] ctrl_en;
    logic [3:0] ctrl_val;
    logic       armed;
    logic       fired;

    int vectors;
    int miscompares;

    patch_control_unit #(
        .OBS_W  (4),
        .CTRL_W (4),
        .HOLD_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .obs_in    (obs_in),
        .ctrl_en   (ctrl_en),
        .ctrl_val  (ctrl_val),
        .armed     (armed),
        .fired     (fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offers frame bits lo..hi, one per cycle, and returns at the negedge
    // after the last bit has been consumed with cfg_valid dropped.
    task automatic send_range(input logic [23:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_data  = f[i];
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ctrl_en"},   32'(ctrl_en),   32'h0);
        chk({tag, ".ctrl_val"},  32'(ctrl_val),  32'h0);
        chk({tag, ".armed"},     32'(armed),     32'h0);
        chk({tag, ".fired"},     32'(fired),     32'h0);
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'h1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = 1'b0;
        obs_in      = 4'b1110;

        // Reset state
        tick(2);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Non-matching obs: no fire
        send_range(F_TIMED, 0, 23);
        chk("nomatch.armed_after_load", 32'(armed), 32'h1);
        tick(5);
        chk("nomatch.ctrl_en", 32'(ctrl_en), 32'h0);
        chk("nomatch.fired",   32'(fired),   32'h0);
        chk("nomatch.armed",   32'(armed),   32'h1);

        // Timed fire, single-cycle obs pulse, cfg_valid held during FIRE
        obs_in = 4'b1101;
        tick(1);
        obs_in = 4'b1110;
        tick(LAT);
        chk("timed.fired",     32'(fired),     32'h1);
        chk("timed.ctrl_en0",  32'(ctrl_en),   32'h5);
        chk("timed.ctrl_val0", 32'(ctrl_val),  32'h4);
        chk("timed.armed0",    32'(armed),     32'h0);
        chk("timed.ready0",    32'(cfg_ready), 32'h0);
        cfg_valid = 1'b1;
        cfg_data  = 1'b1;
        tick(1);
        chk("timed.fired_pulse", 32'(fired),     32'h0);
        chk("timed.ctrl_en1",    32'(ctrl_en),   32'h5);
        chk("timed.ready1",      32'(cfg_ready), 32'h0);
        tick(1);
        chk("timed.ctrl_en2",    32'(ctrl_en),   32'h5);
        chk("timed.ctrl_val2",   32'(ctrl_val),  32'h4);
        chk("timed.ready2",      32'(cfg_ready), 32'h0);
        tick(1);
        chk("timed.expired_en", 32'(ctrl_en), 32'h0);
        chk("timed.rearmed",    32'(armed),   32'h1);
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;

        // Continuous match: expiry goes to ARMED for a cycle, then fires again
        obs_in = 4'b1101;
        tick(1 + LAT);
        chk("rematch.fired0", 32'(fired), 32'h1);
        tick(2);
        chk("rematch.en_last", 32'(ctrl_en), 32'h5);
        tick(1);
        chk("rematch.armed_gap", 32'(armed),   32'h1);
        chk("rematch.en_gap",    32'(ctrl_en), 32'h0);
        chk("rematch.fired_gap", 32'(fired),   32'h0);
        tick(1);
        chk("rematch.fired1", 32'(fired),   32'h1);
        chk("rematch.en1",    32'(ctrl_en), 32'h5);
        obs_in = 4'b1110;
        tick(3);
        chk("rematch.armed_end", 32'(armed), 32'h1);

        // Asynchronous reset mid-FIRE
        obs_in = 4'b1101;
        tick(1 + LAT);
        chk("midfire.en", 32'(ctrl_en), 32'h5);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_fire");
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        chk("rst_fire.idle_en",    32'(ctrl_en), 32'h0);
        chk("rst_fire.idle_armed", 32'(armed),   32'h0);
        obs_in = 4'b1110;

        // Asynchronous reset at LOAD bit 10: a full new frame is then required
        send_range(F_TIMED, 0, 9);
        chk("load10.armed", 32'(armed), 32'h0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_load");
        @(negedge clk);
        rst_n = 1'b1;
        send_range(F_TIMED, 0, 22);
        chk("reload.armed_23", 32'(armed), 32'h0);
        send_range(F_TIMED, 23, 23);
        chk("reload.armed_24", 32'(armed), 32'h1);

        // Sticky FIRE: reconfigure from ARMED, then hold 50 cycles
        send_range(F_STICKY, 0, 23);
        chk("sticky.armed", 32'(armed), 32'h1);
        obs_in = 4'b1101;
        tick(1 + LAT);
        chk("sticky.fired", 32'(fired), 32'h1);
        obs_in = 4'b1110;
        tick(50);
        chk("sticky.en50",    32'(ctrl_en),   32'h5);
        chk("sticky.val50",   32'(ctrl_val),  32'h4);
        chk("sticky.ready50", 32'(cfg_ready), 32'h1);
        chk("sticky.armed50", 32'(armed),     32'h0);
        // Aborting bit is F_TIMED bit 0; only 23 more bits then complete it
        send_range(F_TIMED, 0, 0);
        chk("abort.en",    32'(ctrl_en),  32'h0);
        chk("abort.val",   32'(ctrl_val), 32'h0);
        chk("abort.armed", 32'(armed),    32'h0);
        send_range(F_TIMED, 1, 23);
        chk("abort.reload_armed", 32'(armed), 32'h1);
        obs_in = 4'b1101;
        tick(1);
        obs_in = 4'b1110;
        tick(LAT);
        chk("abort.timed_fired", 32'(fired), 32'h1);
        tick(2);
        chk("abort.timed_en2", 32'(ctrl_en), 32'h5);
        tick(1);
        chk("abort.timed_armed", 32'(armed), 32'h1);

        // match_mask == 0 never fires
        send_range(F_NOMASK, 0, 23);
        chk("nomask.armed", 32'(armed), 32'h1);
        obs_in = 4'b0000;
        tick(1 + LAT);
        chk("nomask.en_0000", 32'(ctrl_en), 32'h0);
        obs_in = 4'b0101;
        tick(1 + LAT);
        chk("nomask.en_0101", 32'(ctrl_en), 32'h0);
        obs_in = 4'b1111;
        tick(1 + LAT);
        chk("nomask.en_1111", 32'(ctrl_en), 32'h0);
        chk("nomask.armed_end", 32'(armed), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
